// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Main control FSM for the multicycle MIPS processor. Sequences the shared
//   datapath (one ALU, one unified instruction/data memory, one register
//   file) through fetch, decode, execute, memory and writeback steps, and
//   drives the enables and mux selects for PC, IR, memory, register file
//   and ALU. Outputs are a pure decode of the current state, except for the
//   FETCH loads (which follow MemReady) and the IllegalOp pulse in DECODE.
//
// Optional feature macro:
//   MC_CTRL_BNE_EN - when defined, opcode 000101 (bne) decodes to the BNEBR
//                    state and BranchNE is driven there. When undefined,
//                    000101 is treated as illegal and BranchNE is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, forces FETCH
//   Op         in   opcode field IR[31:26], width WIDTH+1
//   MemReady   in   memory finished the current read/write this cycle
//   PCWrite    out  unconditional PC load
//   Branch     out  PC load when ALU Zero=1 (beq)
//   BranchNE   out  PC load when ALU Zero=0 (bne)
//   IorD       out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load
//   RegDst     out  write register select (1 = rd, 0 = rt)
//   MemtoReg   out  write data select (1 = MDR, 0 = ALUOut)
//   RegWrite   out  register file write
//   ALUSrcA    out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   ALUOp      out  00 add, 01 subtract, 10 funct-decoded
//   PCSrc      out  00 ALU result, 01 ALUOut, 10 jump target
//   IllegalOp  out  one-cycle pulse for an unknown opcode in DECODE
//   State      out  current state code, for debug
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH:0]   Op,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             Branch,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             IllegalOp,
  output logic [3:0]       State
);

  // State codes are visible on the State port, so the encoding is fixed.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNEBR    = 4'd12
  } state_t;

  // Coarse instruction class derived from the opcode in DECODE.
  typedef enum logic [2:0] {
    OPC_RTYPE   = 3'd0,
    OPC_MEM     = 3'd1,
    OPC_BEQ     = 3'd2,
    OPC_ADDI    = 3'd3,
    OPC_JUMP    = 3'd4,
    OPC_BNE     = 3'd5,
    OPC_ILLEGAL = 3'd6
  } opClass_t;

  localparam logic [WIDTH:0] OP_RTYPE = (WIDTH+1)'(6'b000000);
  localparam logic [WIDTH:0] OP_LW    = (WIDTH+1)'(6'b100011);
  localparam logic [WIDTH:0] OP_SW    = (WIDTH+1)'(6'b101011);
  localparam logic [WIDTH:0] OP_BEQ   = (WIDTH+1)'(6'b000100);
  localparam logic [WIDTH:0] OP_ADDI  = (WIDTH+1)'(6'b001000);
  localparam logic [WIDTH:0] OP_J     = (WIDTH+1)'(6'b000010);
  localparam logic [WIDTH:0] OP_BNE   = (WIDTH+1)'(6'b000101);

  state_t   r_state;
  state_t   w_nextState;
  opClass_t w_opClass;

  // Classify the opcode. Only meaningful while the IR is stable, i.e. in
  // DECODE and MEMADR; elsewhere the result is simply ignored.
  always_comb begin
    w_opClass = OPC_ILLEGAL;
    if (Op == OP_RTYPE) begin
      w_opClass = OPC_RTYPE;
    end else if ((Op == OP_LW) || (Op == OP_SW)) begin
      w_opClass = OPC_MEM;
    end else if (Op == OP_BEQ) begin
      w_opClass = OPC_BEQ;
    end else if (Op == OP_ADDI) begin
      w_opClass = OPC_ADDI;
    end else if (Op == OP_J) begin
      w_opClass = OPC_JUMP;
`ifdef MC_CTRL_BNE_EN
    end else if (Op == OP_BNE) begin
      w_opClass = OPC_BNE;
`endif
    end
  end

  // State register. Reset is asynchronous so a mid-instruction reset drops
  // straight back to FETCH and kills any pending writeback or store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Memory states wait on MemReady with no timeout;
  // unused codes (and BNEBR when bne is disabled) fall back to FETCH.
  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH: begin
        w_nextState = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        case (w_opClass)
          OPC_RTYPE: w_nextState = EXECUTE;
          OPC_MEM:   w_nextState = MEMADR;
          OPC_BEQ:   w_nextState = BRANCH;
          OPC_ADDI:  w_nextState = ADDIEXEC;
          OPC_JUMP:  w_nextState = JUMP;
`ifdef MC_CTRL_BNE_EN
          OPC_BNE:   w_nextState = BNEBR;
`endif
          default:   w_nextState = FETCH;
        endcase
      end
      MEMADR: begin
        w_nextState = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_nextState = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        w_nextState = FETCH;
      end
      MEMWR: begin
        w_nextState = MemReady ? FETCH : MEMWR;
      end
      EXECUTE: begin
        w_nextState = ALUWB;
      end
      ALUWB: begin
        w_nextState = FETCH;
      end
      BRANCH: begin
        w_nextState = FETCH;
      end
      ADDIEXEC: begin
        w_nextState = ADDIWB;
      end
      ADDIWB: begin
        w_nextState = FETCH;
      end
      JUMP: begin
        w_nextState = FETCH;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  // Output decode. Everything defaults to 0 so no state can drive X.
  // The FETCH loads and IllegalOp are additionally masked by reset, since
  // the state already reads FETCH while reset is held and MemReady may be 1.
  always_comb begin
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    BranchNE  = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    IllegalOp = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcB = 2'b01;
        PCWrite = MemReady & ~reset;
        IRWrite = MemReady & ~reset;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = (w_opClass == OPC_ILLEGAL) & ~reset;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      BNEBR: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        BranchNE = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Randomized instruction stream against a step-list reference model. Each
// instruction is expanded into the list of (state, MemReady, Op) steps the
// controller should walk through, including random memory stalls, and every
// cycle the State port and all control outputs are compared against the
// expected control word for that step. A directed reset during ADDIEXEC
// checks the asynchronous abort.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, Branch, BranchNE, IorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  int checkCount;
  int errorCount;

  typedef struct packed {
    logic       PCWrite;
    logic       Branch;
    logic       BranchNE;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       IllegalOp;
  } ctrl_t;

  typedef struct {
    int         st;
    bit         mr;
    logic [5:0] op;
    bit         ill;
  } step_t;

  step_t plan[$];
  ctrl_t observed;

  multicycle_control #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .IllegalOp(IllegalOp), .State(State)
  );

  assign observed = '{PCWrite, Branch, BranchNE, IorD, MemWrite, IRWrite,
                      RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                      PCSrc, IllegalOp};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errorCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control word for a state, written straight from the per-state
  // output list. mr and ill cover the two input-dependent outputs.
  function automatic ctrl_t expOut(input int st, input bit mr, input bit ill);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.ALUSrcB = 2'b01; c.PCWrite = mr; c.IRWrite = mr; end
      1:  begin c.ALUSrcB = 2'b11; c.IllegalOp = ill; end
      2:  begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      3:  begin c.IorD = 1'b1; end
      4:  begin c.MemtoReg = 1'b1; c.RegWrite = 1'b1; end
      5:  begin c.IorD = 1'b1; c.MemWrite = 1'b1; end
      6:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b10; end
      7:  begin c.RegDst = 1'b1; c.RegWrite = 1'b1; end
      8:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCSrc = 2'b01; c.Branch = 1'b1; end
      9:  begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      10: begin c.RegWrite = 1'b1; end
      11: begin c.PCSrc = 2'b10; c.PCWrite = 1'b1; end
      12: begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCSrc = 2'b01; c.BranchNE = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic void push(input int st, input bit mr, input logic [5:0] op, input bit ill);
    step_t s;
    s.st = st; s.mr = mr; s.op = op; s.ill = ill;
    plan.push_back(s);
  endfunction

  // Expand one instruction into its expected step list.
  function automatic void buildPlan(input logic [5:0] op, input int fStall, input int mStall);
    bit ill;
    ill = 1'b0;
    for (int i = 0; i < fStall; i++) push(0, 1'b0, 6'($urandom), 1'b0);
    push(0, 1'b1, 6'($urandom), 1'b0);
    case (op)
      6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b100011, 6'b101011: ill = 1'b0;
`ifdef MC_CTRL_BNE_EN
      6'b000101: ill = 1'b0;
`endif
      default: ill = 1'b1;
    endcase
    push(1, 1'($urandom), op, ill);
    case (op)
      6'b000000: begin push(6, 1'($urandom), op, 0); push(7, 1'($urandom), op, 0); end
      6'b100011: begin
        push(2, 1'($urandom), op, 0);
        for (int i = 0; i < mStall; i++) push(3, 1'b0, op, 0);
        push(3, 1'b1, op, 0);
        push(4, 1'($urandom), op, 0);
      end
      6'b101011: begin
        push(2, 1'($urandom), op, 0);
        for (int i = 0; i < mStall; i++) push(5, 1'b0, op, 0);
        push(5, 1'b1, op, 0);
      end
      6'b000100: push(8, 1'($urandom), op, 0);
      6'b001000: begin push(9, 1'($urandom), op, 0); push(10, 1'($urandom), op, 0); end
      6'b000010: push(11, 1'($urandom), op, 0);
`ifdef MC_CTRL_BNE_EN
      6'b000101: push(12, 1'($urandom), op, 0);
`endif
      default: ;
    endcase
  endfunction

  // Drive each planned step on the falling edge and check just after.
  task automatic applyStimulus();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      MemReady = s.mr;
      Op       = s.op;
      #1;
      checkOutput($sformatf("state(exp %0d)", s.st), 32'(State), 32'(s.st));
      checkOutput($sformatf("ctrl(st %0d)", s.st), 32'(observed), 32'(expOut(s.st, s.mr, s.ill)));
    end
  endtask

  function automatic logic [5:0] pickOp();
    logic [5:0] ops [8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b000010, 6'b000101, 6'b111111};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 7)];
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    MemReady   = 1'b1;
    Op         = 6'b000000;

    // Reset state with MemReady high: loads must stay masked.
    @(negedge clk);
    #1;
    checkOutput("resetState", 32'(State), 32'd0);
    checkOutput("resetCtrl", 32'(observed), 32'(expOut(0, 1'b0, 1'b0)));
    MemReady = 1'b0;
    reset    = 1'b0;

    // Directed test-plan sequences first, then random instructions.
    buildPlan(6'b000000, 0, 0);
    buildPlan(6'b100011, 0, 2);
    buildPlan(6'b101011, 1, 0);
    buildPlan(6'b000100, 0, 0);
    buildPlan(6'b000010, 0, 0);
    buildPlan(6'b111111, 0, 0);
    buildPlan(6'b000101, 0, 0);
    applyStimulus();

    for (int n = 0; n < 80; n++) begin
      buildPlan(pickOp(), $urandom_range(0, 2), $urandom_range(0, 3));
      applyStimulus();
    end

    // Abort an addi in ADDIEXEC with an asynchronous reset.
    buildPlan(6'b001000, 0, 0);
    void'(plan.pop_back());
    applyStimulus();
    #1;
    MemReady = 1'b1;
    reset    = 1'b1;
    #1;
    checkOutput("asyncResetState", 32'(State), 32'd0);
    checkOutput("asyncResetCtrl", 32'(observed), 32'(expOut(0, 1'b0, 1'b0)));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("heldResetState", 32'(State), 32'd0);
      checkOutput("heldResetRegWrite", 32'(RegWrite), 32'd0);
    end
    @(negedge clk);
    MemReady = 1'b0;
    reset    = 1'b0;

    for (int n = 0; n < 20; n++) begin
      buildPlan(pickOp(), $urandom_range(0, 2), $urandom_range(0, 3));
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
